// File: rtl/tag_pkg.sv
// Shared types and default sizes for the cache tag lookup controller.
package tag_pkg;

    localparam int TAG_W_DEF = 20;
    localparam int IDX_W_DEF = 10;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
    } tag_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/tag_lookup_ctrl_if.sv
// Lookup request/response channel between the cache pipeline (master)
// and the tag lookup controller (slave).
interface tag_lookup_ctrl_if #(
    parameter int TAG_W = 20,
    parameter int IDX_W = 10
);
    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] req_index;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_hit;
    logic [IDX_W-1:0] rsp_index;

    modport master (
        output req_valid, req_index, req_tag,
        input  req_ready, rsp_valid, rsp_hit, rsp_index
    );

    modport slave (
        input  req_valid, req_index, req_tag,
        output req_ready, rsp_valid, rsp_hit, rsp_index
    );
endinterface

// File: rtl/tag_sweep_fsm.sv
// Invalidate-sweep sequencer: walks every set index once after reset or flush,
// then spends one settle cycle in DONE before handing control back to IDLE.
module tag_sweep_fsm
    import tag_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush_req,
    output logic             is_idle,
    output logic             flush_busy,
    output logic             sweep_we,
    output logic [IDX_W-1:0] sweep_addr
);
    // One extra counter bit so the terminal compare never wraps to zero.
    localparam logic [IDX_W:0] CNT_END = {1'b1, {IDX_W{1'b0}}};

    sweep_state_t   state_q, state_d;
    logic [IDX_W:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_we = 1'b0;
        unique case (state_q)
            SWEEP: begin
                sweep_we = 1'b1;
                cnt_d    = cnt_q + (IDX_W+1)'(1);
                if (cnt_d == CNT_END) state_d = DONE;
            end
            DONE: state_d = IDLE;
            IDLE: begin
                if (flush_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign is_idle    = (state_q == IDLE);
    assign flush_busy = (state_q == SWEEP);
    assign sweep_addr = cnt_q[IDX_W-1:0];
endmodule

// File: rtl/tag_lookup_ctrl.sv
// Tag RAM front end: lookup with one-cycle hit/miss, refill writes with
// same-cycle forwarding, invalidate sweep. Optional counters: TAG_LOOKUP_STATS_EN.
module tag_lookup_ctrl
    import tag_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    tag_lookup_ctrl_if.slave lk,
    input  logic             fill_valid,
    input  logic [IDX_W-1:0] fill_index,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             tr_ena,
    output logic             tr_wea,
    output logic [IDX_W-1:0] tr_addra,
    output logic [TAG_W:0]   tr_dina,
    output logic             tr_enb,
    output logic [IDX_W-1:0] tr_addrb,
    input  logic [TAG_W:0]   tr_doutb
`ifdef TAG_LOOKUP_STATS_EN
    ,
    output logic [31:0]      stat_hits,
    output logic [31:0]      stat_misses
`endif
);
    logic             is_idle, sweep_we, accept, fill_en;
    logic [IDX_W-1:0] sweep_addr;
    logic [TAG_W:0]   s1_entry;

    logic             s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0] s1_index_q, s1_index_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_fwd_q, s1_fwd_d;
    logic [TAG_W:0]   s1_fwd_entry_q, s1_fwd_entry_d;

    tag_sweep_fsm #(.IDX_W(IDX_W)) u_sweep (
        .clk        (clk),
        .resetn     (resetn),
        .flush_req  (flush_req),
        .is_idle    (is_idle),
        .flush_busy (flush_busy),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    assign lk.req_ready = is_idle;
    assign accept       = lk.req_valid && is_idle;
    assign fill_en      = fill_valid && is_idle;

    // RAM enables are held low while reset is asserted.
    always_comb begin
        tr_ena   = resetn && (sweep_we || fill_en);
        tr_wea   = tr_ena;
        tr_addra = sweep_we ? sweep_addr : fill_index;
        tr_dina  = sweep_we ? '0 : {1'b1, fill_tag};
        tr_enb   = resetn && accept;
        tr_addrb = lk.req_index;
    end

    // A fill landing in the accept cycle is not yet visible in the RAM read data.
    always_comb begin
        s1_valid_d     = accept;
        s1_index_d     = accept ? lk.req_index : s1_index_q;
        s1_tag_d       = accept ? lk.req_tag : s1_tag_q;
        s1_fwd_d       = accept && fill_en && (fill_index == lk.req_index);
        s1_fwd_entry_d = {1'b1, fill_tag};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid_q     <= 1'b0;
            s1_index_q     <= '0;
            s1_tag_q       <= '0;
            s1_fwd_q       <= 1'b0;
            s1_fwd_entry_q <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_index_q     <= s1_index_d;
            s1_tag_q       <= s1_tag_d;
            s1_fwd_q       <= s1_fwd_d;
            s1_fwd_entry_q <= s1_fwd_entry_d;
        end
    end

    assign s1_entry     = s1_fwd_q ? s1_fwd_entry_q : tr_doutb;
    assign lk.rsp_valid = s1_valid_q;
    assign lk.rsp_index = s1_index_q;
    assign lk.rsp_hit   = s1_valid_q && s1_entry[TAG_W] && (s1_entry[TAG_W-1:0] == s1_tag_q);

`ifdef TAG_LOOKUP_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d, stat_misses_q, stat_misses_d;

    // Saturating counters; only reset clears them, a flush does not.
    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (lk.rsp_valid && lk.rsp_hit && (stat_hits_q != '1))
            stat_hits_d = stat_hits_q + 32'd1;
        if (lk.rsp_valid && !lk.rsp_hit && (stat_misses_q != '1))
            stat_misses_d = stat_misses_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif
endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Directed bench for tag_lookup_ctrl with IDX_W=4 and a behavioural tag RAM.
module tb_tag_lookup_ctrl;
    localparam int TW = 20;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          rst_next;
    logic          fill_valid;
    logic [IW-1:0] fill_index;
    logic [TW-1:0] fill_tag;
    logic          flush_req;
    logic          flush_busy;
    logic          tr_ena, tr_wea, tr_enb;
    logic [IW-1:0] tr_addra, tr_addrb;
    logic [TW:0]   tr_dina, tr_doutb;
`ifdef TAG_LOOKUP_STATS_EN
    logic [31:0]   stat_hits, stat_misses;
`endif

    logic [TW:0]   mem [0:(1<<IW)-1];
    int            n_checks = 0;
    int            n_errors = 0;
    int            exp_hits = 0;
    int            exp_misses = 0;

    always #5 clk = ~clk;

    tag_lookup_ctrl_if #(.TAG_W(TW), .IDX_W(IW)) lk ();

    tag_lookup_ctrl #(.TAG_W(TW), .IDX_W(IW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .lk         (lk),
        .fill_valid (fill_valid),
        .fill_index (fill_index),
        .fill_tag   (fill_tag),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .tr_ena     (tr_ena),
        .tr_wea     (tr_wea),
        .tr_addra   (tr_addra),
        .tr_dina    (tr_dina),
        .tr_enb     (tr_enb),
        .tr_addrb   (tr_addrb),
        .tr_doutb   (tr_doutb)
`ifdef TAG_LOOKUP_STATS_EN
        ,
        .stat_hits  (stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    // Simple dual-port RAM, registered read, read-before-write.
    always @(posedge clk) begin
        if (tr_ena && tr_wea) mem[tr_addra] <= tr_dina;
        if (tr_enb) tr_doutb <= mem[tr_addrb];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Inputs change right after the falling edge; outputs are sampled 1ns later.
    task automatic cyc_drive(input logic rv, input logic [IW-1:0] ridx, input logic [TW-1:0] rtag,
                             input logic fv, input logic [IW-1:0] fidx, input logic [TW-1:0] ftag,
                             input logic fl);
        @(negedge clk);
        resetn       = rst_next;
        lk.req_valid = rv;
        lk.req_index = ridx;
        lk.req_tag   = rtag;
        fill_valid   = fv;
        fill_index   = fidx;
        fill_tag     = ftag;
        flush_req    = fl;
        #1;
    endtask

    task automatic cyc_idle();
        cyc_drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic cyc_lookup(input logic [IW-1:0] idx, input logic [TW-1:0] tag);
        cyc_drive(1'b1, idx, tag, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic cyc_fill(input logic [IW-1:0] idx, input logic [TW-1:0] tag);
        cyc_drive(1'b0, '0, '0, 1'b1, idx, tag, 1'b0);
    endtask

    task automatic expect_rsp(input string name, input logic [IW-1:0] idx, input logic hit);
        $display("rsp %s: valid=%0d index=%0d hit=%0d (want index=%0d hit=%0d)",
                 name, lk.rsp_valid, lk.rsp_index, lk.rsp_hit, idx, hit);
        check({name, "_valid"}, 32'(lk.rsp_valid), 32'd1);
        check({name, "_index"}, 32'(lk.rsp_index), 32'(idx));
        check({name, "_hit"}, 32'(lk.rsp_hit), 32'(hit));
        if (hit) exp_hits++;
        else exp_misses++;
    endtask

    task automatic expect_none(input string name);
        check({name, "_novalid"}, 32'(lk.rsp_valid), 32'd0);
    endtask

    task automatic check_sweep_cycle(input string name, input int i);
        check({name, "_busy"}, 32'(flush_busy), 32'd1);
        check({name, "_wr"}, 32'({tr_ena, tr_wea, tr_addra, tr_dina}), 32'({2'b11, 4'(i), 21'd0}));
        check({name, "_ready"}, 32'(lk.req_ready), 32'd0);
        check({name, "_enb"}, 32'(tr_enb), 32'd0);
    endtask

    task automatic finish_sweep(input string name);
        cyc_idle();
        check({name, "_done_busy"}, 32'(flush_busy), 32'd0);
        check({name, "_done_ready"}, 32'(lk.req_ready), 32'd0);
        check({name, "_done_ena"}, 32'(tr_ena), 32'd0);
        cyc_idle();
        check({name, "_idle_ready"}, 32'(lk.req_ready), 32'd1);
    endtask

`ifdef TAG_LOOKUP_STATS_EN
    task automatic check_stats(input string name);
        $display("stats %s: hits=%0d misses=%0d", name, stat_hits, stat_misses);
        check({name, "_hits"}, stat_hits, 32'(exp_hits));
        check({name, "_misses"}, stat_misses, 32'(exp_misses));
    endtask
`endif

    initial begin
        resetn = 1'b0; rst_next = 1'b0;
        lk.req_valid = 1'b0; lk.req_index = '0; lk.req_tag = '0;
        fill_valid = 1'b0; fill_index = '0; fill_tag = '0; flush_req = 1'b0;

        // Reset state
        repeat (3) cyc_idle();
        $display("reset: flush_busy=%0d req_ready=%0d", flush_busy, lk.req_ready);
        check("rst_rsp_valid", 32'(lk.rsp_valid), 32'd0);
        check("rst_rsp_hit", 32'(lk.rsp_hit), 32'd0);
        check("rst_rsp_index", 32'(lk.rsp_index), 32'd0);
        check("rst_ena_wea_enb", 32'({tr_ena, tr_wea, tr_enb}), 32'd0);
        check("rst_busy", 32'(flush_busy), 32'd1);
        check("rst_ready", 32'(lk.req_ready), 32'd0);
`ifdef TAG_LOOKUP_STATS_EN
        check_stats("rst");
`endif

        // Power-on sweep: 16 writes of zero, one DONE cycle, then IDLE
        rst_next = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc_idle();
            check_sweep_cycle("init_sweep", i);
        end
        finish_sweep("init");

        // Fill then look up the same set two cycles later
        cyc_fill(4'd5, 20'hABCDE);
        $display("fill idx=5 tag=abcde wr=%0d addr=%0d din=%h", tr_wea, tr_addra, tr_dina);
        check("fill_wr", 32'({tr_ena, tr_wea, tr_addra, tr_dina}), 32'({2'b11, 4'd5, 1'b1, 20'hABCDE}));
        cyc_idle();
        cyc_lookup(4'd5, 20'hABCDE);
        check("lk_rd", 32'({tr_enb, tr_addrb}), 32'({1'b1, 4'd5}));
        expect_none("lk5_lat");
        cyc_lookup(4'd5, 20'h12345);
        expect_rsp("lk5_hit", 4'd5, 1'b1);
        cyc_idle();
        expect_rsp("lk5_miss", 4'd5, 1'b0);
        cyc_idle();
        expect_none("lk5_end");

        // Same-cycle fill forwarding; a fill one cycle late is not visible
        cyc_drive(1'b1, 4'd7, 20'h111, 1'b1, 4'd7, 20'h111, 1'b0);
        cyc_lookup(4'd7, 20'h222);
        expect_rsp("fwd_hit", 4'd7, 1'b1);
        cyc_fill(4'd7, 20'h222);
        expect_rsp("late_fill_miss", 4'd7, 1'b0);
        cyc_lookup(4'd7, 20'h222);
        expect_none("after_late");
        cyc_idle();
        expect_rsp("late_fill_now_hit", 4'd7, 1'b1);

        // Back-to-back lookups; set 1 and 3 are invalid, set 2 holds tag 2
        cyc_fill(4'd2, 20'h2);
        cyc_lookup(4'd1, 20'h0);
        cyc_lookup(4'd2, 20'h2);
        expect_rsp("b2b_1", 4'd1, 1'b0);
        cyc_lookup(4'd3, 20'h0);
        expect_rsp("b2b_2", 4'd2, 1'b1);
        cyc_idle();
        expect_rsp("b2b_3", 4'd3, 1'b0);
`ifdef TAG_LOOKUP_STATS_EN
        check_stats("pre_flush");
`endif

        // Flush with a simultaneous lookup; fills and flush_req during the sweep are dropped
        cyc_fill(4'd9, 20'h99);
        cyc_drive(1'b1, 4'd9, 20'h99, 1'b0, '0, '0, 1'b1);
        check("flush_lk_accept", 32'({lk.req_ready, tr_enb}), 32'({1'b1, 1'b1}));
        for (int i = 0; i < 16; i++) begin
            cyc_drive(1'b1, 4'd9, 20'h99, 1'b1, 4'd9, 20'h55, (i == 10));
            check_sweep_cycle("flush_sweep", i);
            if (i == 0) expect_rsp("flush_lk", 4'd9, 1'b1);
            else expect_none("flush_sweep_rsp");
        end
        finish_sweep("flush");
`ifdef TAG_LOOKUP_STATS_EN
        check_stats("post_flush");
`endif
        cyc_lookup(4'd9, 20'h99);
        cyc_idle();
        expect_rsp("post_flush_lk9", 4'd9, 1'b0);
        cyc_lookup(4'd2, 20'h2);
        cyc_idle();
        expect_rsp("post_flush_lk2", 4'd2, 1'b0);

        // Reset in the middle of a sweep restarts it at index 0
        cyc_drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc_idle();
            check_sweep_cycle("pre_rst_sweep", i);
        end
        rst_next = 1'b0;
        cyc_idle();
        check("midrst_ena", 32'({tr_ena, tr_wea, tr_enb}), 32'd0);
        check("midrst_busy", 32'(flush_busy), 32'd1);
        exp_hits = 0;
        exp_misses = 0;
        rst_next = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc_idle();
            check_sweep_cycle("rst_sweep", i);
        end
        finish_sweep("rst");
`ifdef TAG_LOOKUP_STATS_EN
        check_stats("post_reset");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/tag_lookup_ctrl.md
Name: tag_lookup_ctrl

Overview:
Front-end controller for a simple dual-port cache tag RAM. It accepts lookup requests, issues reads on the RAM read port and compares the returned {valid,tag} to produce hit/miss. It applies refill writes on the RAM write port, with forwarding for same-index collisions, and runs an invalidate sweep after reset or on a flush request. It sits between the cache pipeline and the tag RAM instance, which is external to this block.

Parameters:
TAG_W, 20, tag width in bits; the RAM entry width is TAG_W+1 with valid in the MSB.
IDX_W, 10, set index width; number of sets = 2**IDX_W.

Ports:
clk  in  1  single clock; both RAM ports are driven from it.
resetn  in  1  synchronous, active-low reset.
req_valid  in  1  lookup request valid.
req_ready  out  1  lookup accepted when req_valid && req_ready.
req_index  in  IDX_W  lookup set index.
req_tag  in  TAG_W  lookup tag.
rsp_valid  out  1  lookup result valid, one-cycle pulse.
rsp_hit  out  1  hit flag, meaningful only when rsp_valid=1.
rsp_index  out  IDX_W  index of the responding request.
fill_valid  in  1  refill write request, always accepted unless flushing.
fill_index  in  IDX_W  refill set index.
fill_tag  in  TAG_W  refill tag; written with valid=1.
flush_req  in  1  single-cycle pulse that starts the invalidate sweep.
flush_busy  out  1  high while the sweep runs.
tr_ena  out  1  RAM write-port enable.
tr_wea  out  1  RAM write enable.
tr_addra  out  IDX_W  RAM write address.
tr_dina  out  TAG_W+1  RAM write data {valid,tag}.
tr_enb  out  1  RAM read-port enable.
tr_addrb  out  IDX_W  RAM read address.
tr_doutb  in  TAG_W+1  RAM read data, registered, one cycle after tr_enb.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-low on resetn.
- Reset values: rsp_valid=0, rsp_hit=0, rsp_index=0, tr_ena=0, tr_wea=0, tr_enb=0. State goes to SWEEP with sweep counter 0, so flush_busy=1 and req_ready=0.
- FSM has three states: IDLE, SWEEP, DONE.
  - SWEEP: each cycle drives tr_ena=tr_wea=1, tr_addra=cnt, tr_dina=0, then cnt++. After writing index 2**IDX_W-1 it goes to DONE.
  - DONE: one cycle with flush_busy=0 and req_ready=0, which lets the final write settle. Then IDLE.
  - IDLE: req_ready=1. flush_req moves the FSM to SWEEP next cycle with cnt=0.
- Sweep length: 2**IDX_W cycles in SWEEP plus 1 in DONE.
- Reset mid-sweep restarts the sweep at index 0.
- flush_req during SWEEP or DONE is ignored.
- Lookup: on accept in cycle N, tr_enb=1 and tr_addrb=req_index combinationally. The index and tag are captured in the stage-1 register.
  - In cycle N+1: rsp_valid=1, rsp_index=captured index, rsp_hit = entry.valid && entry.tag==captured tag. The compare is combinational off tr_doutb or the forwarded entry.
  - Throughput is one lookup per cycle, with no backpressure from the response side.
- Refill: in IDLE, fill_valid drives tr_ena=tr_wea=1, tr_addra=fill_index, tr_dina={1,fill_tag} in the same cycle. During SWEEP/DONE fill_valid is dropped.
- Forwarding: a response reflects every fill issued in cycles up to and including N.
  - If a fill in cycle N has the same index as the lookup accepted in N, stage 1 uses the fill's {1,fill_tag} instead of tr_doutb.
  - A fill in cycle N+1 is not visible to the response in N+1.
- Simultaneous flush_req and fill_valid in IDLE: the fill is written, and the sweep starts next cycle and erases it.
- Simultaneous flush_req and req_valid in IDLE: the lookup is accepted and its response is produced in the first SWEEP cycle.
- Counter width: the sweep counter is IDX_W+1 bits so that the terminal test does not wrap.

Optional Feature:
TAG_LOOKUP_STATS_EN
- Defined: adds outputs stat_hits[31:0] and stat_misses[31:0]. Each increments on rsp_valid according to rsp_hit, saturates at 0xFFFFFFFF, and clears on reset. A flush does not clear them.
- Undefined: the ports and counters are absent.

Decomposition:
- Package tag_pkg:
  - typedef tag_entry_t: packed struct {valid, tag[TAG_W-1:0]}.
  - enum sweep_state_t: {IDLE, SWEEP, DONE}.
  - Localparams for default TAG_W/IDX_W.
- One sub-module, tag_sweep_fsm: owns the state, counter, flush_busy and the write-port sweep drive. The top module muxes between the sweep write and the fill write.

Test Plan:
- Reset, then hold resetn=1 with IDX_W=4 -> flush_busy=1 for 16 cycles, tr_addra goes 0..15 with tr_dina=0, DONE lasts 1 cycle, then req_ready=1.
- Fill idx 5 tag 0xABCDE; lookup idx 5 tag 0xABCDE two cycles later -> rsp_valid one cycle after accept, rsp_hit=1, rsp_index=5. Lookup idx 5 tag 0x12345 -> rsp_hit=0.
- Fill idx 7 tag 0x111 and lookup idx 7 tag 0x111 in the same cycle -> forwarded, rsp_hit=1. Fill idx 7 tag 0x222 the cycle after a lookup of 0x222 -> rsp_hit=0.
- Back-to-back lookups on idx 1,2,3 for 3 cycles -> three consecutive rsp_valid pulses in order with matching rsp_index.
- Fill idx 9, then flush_req, wait for the sweep, then look up idx 9 -> rsp_hit=0. Fills during the sweep produce no tr_wea to the fill index. Asserting resetn=0 mid-sweep restarts the sweep at tr_addra=0.
- With TAG_LOOKUP_STATS_EN: 3 hits and 2 misses -> stat_hits=3, stat_misses=2. A flush leaves both unchanged.
